// File: rtl/orlink_rx_deframer_pkg.sv
// Shared definitions for the orlink receive deframer: sync marker, FSM states
// and the byte-wise CRC-16 (poly 0x1021, MSB first) update used by the engine.
package orlink_rx_deframer_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam logic [15:0] CRC_POLY      = 16'h1021;
  localparam logic [15:0] CRC_INIT      = 16'h0000;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CRC_HI,
    ST_CRC_LO
  } state_e;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] din);
    logic [15:0] c;
    c = crc ^ {din, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/orlink_crc16.sv
// Byte-wise CRC-16 engine; synchronous clear, result valid the cycle after en.
module orlink_crc16
  import orlink_rx_deframer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [15:0] dout
);

  logic [15:0] crc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= CRC_INIT;
    end else if (en) begin
      crc_q <= crc16_byte(crc_q, din);
    end
  end

  assign dout = crc_q;

endmodule

// File: rtl/orlink_rx_deframer.sv
// orlink receive deframer: hunts for sync, forwards the payload cut-through,
// checks the trailing CRC-16 and tracks CRC failures and inter-byte timeouts.
module orlink_rx_deframer
  import orlink_rx_deframer_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             pkt_done,
  output logic             pkt_ok,
  output logic [CNT_W-1:0] crc_err_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  localparam int unsigned TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_e             state_q;
  logic [7:0]         rem_q;
  logic [7:0]         crc_hi_q;
  logic [TMO_W-1:0]   tmo_q;
  logic               pkt_done_q;
  logic               pkt_ok_q;
  logic [CNT_W-1:0]   crc_err_cnt_q;
  logic [CNT_W-1:0]   timeout_cnt_q;

  logic               in_fire;
  logic               in_payload;
  logic               start_clear;
  logic               crc_en;
  logic               crc_rst;
  logic [15:0]        crc_val;
  logic [15:0]        rx_crc;
  logic               tmo_armed;
  logic               tmo_expire;
  logic [TMO_W-1:0]   tmo_d;
  logic [CNT_W-1:0]   crc_err_cnt_d;
  logic [CNT_W-1:0]   timeout_cnt_d;

  assign in_payload = (state_q == ST_PAYLOAD);
  assign in_ready   = !rst && (in_payload ? out_ready : 1'b1);
  assign in_fire    = in_valid && in_ready;

  assign out_valid  = in_payload && in_valid;
  assign out_data   = in_payload ? in_data : 8'h00;
  assign out_last   = in_payload && (rem_q == 8'd1);

  assign start_clear = (state_q == ST_HUNT) && in_fire && (in_data == SYNC_BYTE);
  assign crc_en      = in_payload && in_fire;
  assign crc_rst     = rst | start_clear;
  assign rx_crc      = {crc_hi_q, in_data};

  // A downstream stall in PAYLOAD is not the sender's fault, so it never ages the packet.
  assign tmo_armed  = (state_q != ST_HUNT) && !in_fire && !(in_payload && !out_ready);
  assign tmo_expire = (TIMEOUT != 0) && tmo_armed && (tmo_q == TMO_W'(TIMEOUT - 1));
  assign tmo_d      = tmo_q + TMO_W'(1);

  assign crc_err_cnt_d = (crc_err_cnt_q == '1) ? crc_err_cnt_q : crc_err_cnt_q + CNT_W'(1);
  assign timeout_cnt_d = (timeout_cnt_q == '1) ? timeout_cnt_q : timeout_cnt_q + CNT_W'(1);

  orlink_crc16 u_crc (
    .clk  (clk),
    .rst  (crc_rst),
    .en   (crc_en),
    .din  (in_data),
    .dout (crc_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_HUNT;
      rem_q         <= '0;
      crc_hi_q      <= '0;
      tmo_q         <= '0;
      pkt_done_q    <= 1'b0;
      pkt_ok_q      <= 1'b0;
      crc_err_cnt_q <= '0;
      timeout_cnt_q <= '0;
    end else begin
      pkt_done_q <= 1'b0;
      pkt_ok_q   <= 1'b0;

      if (state_q == ST_HUNT || in_fire) begin
        tmo_q <= '0;
      end else if (tmo_armed) begin
        tmo_q <= tmo_d;
      end

      unique case (state_q)
        ST_HUNT: begin
          if (start_clear) state_q <= ST_LEN;
        end
        ST_LEN: begin
          if (in_fire) begin
            rem_q   <= in_data;
            state_q <= (in_data == 8'd0) ? ST_CRC_HI : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (in_fire) begin
            rem_q <= rem_q - 8'd1;
            if (rem_q == 8'd1) state_q <= ST_CRC_HI;
          end
        end
        ST_CRC_HI: begin
          if (in_fire) begin
            crc_hi_q <= in_data;
            state_q  <= ST_CRC_LO;
          end
        end
        ST_CRC_LO: begin
          if (in_fire) begin
            pkt_done_q <= 1'b1;
            pkt_ok_q   <= (crc_val == rx_crc);
            if (crc_val != rx_crc) crc_err_cnt_q <= crc_err_cnt_d;
            state_q    <= ST_HUNT;
          end
        end
        default: state_q <= ST_HUNT;
      endcase

      // Expiry only fires on a cycle without a transfer, so an arriving byte always wins.
      if (tmo_expire) begin
        state_q       <= ST_HUNT;
        tmo_q         <= '0;
        timeout_cnt_q <= timeout_cnt_d;
      end
    end
  end

  assign pkt_done    = pkt_done_q;
  assign pkt_ok      = pkt_ok_q;
  assign crc_err_cnt = crc_err_cnt_q;
  assign timeout_cnt = timeout_cnt_q;

endmodule
